// File: rtl/synth_pkg.sv
// Shared types and constants for the synthesizer voice path.
package synth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        DECAY,
        SUSTAIN,
        RELEASE
    } adsr_state_t;

    localparam logic [7:0] WAVE_MID = 8'd128;
    localparam logic [7:0] ENV_MAX  = 8'd255;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one-clock tick every PRESCALE clocks.
module tick_prescaler #(
    parameter int PRESCALE = 1000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = $clog2(PRESCALE);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(PRESCALE - 1));
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope generator scaling an oscillator sample about midscale.
module adsr_envelope
    import synth_pkg::*;
#(
    parameter int PRESCALE = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] wave_in,
    input  logic       gate,
    input  logic [7:0] attack_step,
    input  logic [7:0] decay_step,
    input  logic [7:0] sustain_level,
    input  logic [7:0] release_step,
    output logic [7:0] wave_out,
    output logic [7:0] env_level,
    output logic       active
);

    adsr_state_t state_q, state_d;
    logic [7:0]  env_q, env_d;
    logic [7:0]  wave_q, wave_d;
    logic        active_q, active_d;
    logic        gate_q, gate_d;
    logic        tick, rise, fall;
    logic [8:0]  att_sum, dec_thr;

    logic signed [8:0]  s;
    logic signed [8:0]  e;
    logic signed [17:0] p;

    tick_prescaler #(.PRESCALE(PRESCALE)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        gate_d  = gate;
        rise    = gate & ~gate_q;
        fall    = ~gate & gate_q;
        state_d = state_q;
        env_d   = env_q;
        att_sum = {1'b0, env_q} + {1'b0, attack_step};
        dec_thr = {1'b0, sustain_level} + {1'b0, decay_step};
        // Gate edges win over a coincident tick: no env step that cycle.
        unique case (state_q)
            IDLE: begin
                env_d = '0;
                if (rise) state_d = ATTACK;
            end
            ATTACK: begin
                if (fall) begin
                    state_d = RELEASE;
                end else if (tick) begin
                    if (att_sum >= 9'd255 || attack_step == '0) begin
                        env_d   = ENV_MAX;
                        state_d = DECAY;
                    end else begin
                        env_d = att_sum[7:0];
                    end
                end
            end
            DECAY: begin
                if (fall) begin
                    state_d = RELEASE;
                end else if (tick) begin
                    if ({1'b0, env_q} <= dec_thr || decay_step == '0 ||
                        sustain_level >= env_q) begin
                        env_d   = sustain_level;
                        state_d = SUSTAIN;
                    end else begin
                        env_d = env_q - decay_step;
                    end
                end
            end
            SUSTAIN: begin
                if (fall) state_d = RELEASE;
                else      env_d   = sustain_level;
            end
            RELEASE: begin
                if (rise) begin
                    state_d = ATTACK;
                end else if (tick) begin
                    if (env_q <= release_step || release_step == '0) begin
                        env_d   = '0;
                        state_d = IDLE;
                    end else begin
                        env_d = env_q - release_step;
                    end
                end
            end
            default: begin
                env_d   = '0;
                state_d = IDLE;
            end
        endcase
        active_d = (state_d != IDLE);
    end

    // Signed sample times envelope, floor-shifted back to 8 bits.
    always_comb begin
        s      = $signed({1'b0, wave_in} - 9'd128);
        e      = $signed({1'b0, env_q});
        p      = s * e;
        wave_d = 8'(p >>> 8) + WAVE_MID;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            env_q    <= '0;
            wave_q   <= WAVE_MID;
            active_q <= 1'b0;
            gate_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            env_q    <= env_d;
            wave_q   <= wave_d;
            active_q <= active_d;
            gate_q   <= gate_d;
        end
    end

    assign wave_out  = wave_q;
    assign env_level = env_q;
    assign active    = active_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope with PRESCALE=4.
module tb_adsr_envelope;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] wave_in = 8'd128;
    logic       gate = 1'b0;
    logic [7:0] attack_step = 8'd0;
    logic [7:0] decay_step = 8'd0;
    logic [7:0] sustain_level = 8'd0;
    logic [7:0] release_step = 8'd0;
    logic [7:0] wave_out;
    logic [7:0] env_level;
    logic       active;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    adsr_envelope #(.PRESCALE(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .wave_in       (wave_in),
        .gate          (gate),
        .attack_step   (attack_step),
        .decay_step    (decay_step),
        .sustain_level (sustain_level),
        .release_step  (release_step),
        .wave_out      (wave_out),
        .env_level     (env_level),
        .active        (active)
    );

    always #5 clk = ~clk;

    // Edge k after reset release is a tick edge when k % 4 == 0.
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic align();
        while ((cyc + 1) % 4 != 0) step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        wave_in = 8'd255;
        gate = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (wave_out !== 8'd128 || env_level !== 8'd0 || active !== 1'b0)
            $display("FAIL reset_hold got w=%0d e=%0d a=%0b want 128/0/0",
                     wave_out, env_level, active);
        else passed++;
        gate = 1'b0;
        wave_in = 8'd128;
        reset = 1'b1;
        cyc = 0;
        step();
        total++;
        if (active !== 1'b0 || env_level !== 8'd0)
            $display("FAIL idle_after_reset got e=%0d a=%0b want 0/0",
                     env_level, active);
        else passed++;
    endtask

    task automatic test_attack_decay();
        logic [7:0] exp_a [4] = '{8'd64, 8'd128, 8'd192, 8'd255};
        logic [7:0] exp_d [4] = '{8'd205, 8'd155, 8'd105, 8'd100};
        attack_step = 8'd64;
        decay_step = 8'd50;
        sustain_level = 8'd100;
        align();
        gate = 1'b1;
        step();
        total++;
        if (active !== 1'b1 || env_level !== 8'd0)
            $display("FAIL attack_start got e=%0d a=%0b want 0/1",
                     env_level, active);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            repeat (4) step();
            total++;
            if (env_level !== exp_a[i])
                $display("FAIL attack_env[%0d] got %0d want %0d",
                         i, env_level, exp_a[i]);
            else passed++;
        end
        for (int i = 0; i < 4; i++) begin
            repeat (4) step();
            total++;
            if (env_level !== exp_d[i])
                $display("FAIL decay_env[%0d] got %0d want %0d",
                         i, env_level, exp_d[i]);
            else passed++;
        end
        repeat (9) step();
        total++;
        if (env_level !== 8'd100 || active !== 1'b1)
            $display("FAIL sustain_hold got e=%0d a=%0b want 100/1",
                     env_level, active);
        else passed++;
        sustain_level = 8'd60;
        step();
        total++;
        if (env_level !== 8'd60)
            $display("FAIL sustain_track got %0d want 60", env_level);
        else passed++;
        wave_in = 8'd255;
        step();
        total++;
        if (wave_out !== 8'd157)
            $display("FAIL scale_env60 got %0d want 157", wave_out);
        else passed++;
        #2;
        reset = 1'b0;
        gate = 1'b0;
        #1;
        total++;
        if (wave_out !== 8'd128 || env_level !== 8'd0 || active !== 1'b0)
            $display("FAIL async_reset got w=%0d e=%0d a=%0b want 128/0/0",
                     wave_out, env_level, active);
        else passed++;
        #2;
        reset = 1'b1;
        cyc = 0;
        wave_in = 8'd128;
    endtask

    task automatic test_early_release();
        attack_step = 8'd64;
        release_step = 8'd100;
        align();
        gate = 1'b1;
        step();
        repeat (8) step();
        total++;
        if (env_level !== 8'd128)
            $display("FAIL rel_pre got %0d want 128", env_level);
        else passed++;
        gate = 1'b0;
        step();
        total++;
        if (env_level !== 8'd128 || active !== 1'b1)
            $display("FAIL rel_fall got e=%0d a=%0b want 128/1",
                     env_level, active);
        else passed++;
        repeat (3) step();
        total++;
        if (env_level !== 8'd28)
            $display("FAIL rel_step1 got %0d want 28", env_level);
        else passed++;
        repeat (4) step();
        total++;
        if (env_level !== 8'd0 || active !== 1'b0)
            $display("FAIL rel_done got e=%0d a=%0b want 0/0",
                     env_level, active);
        else passed++;
        align();
        gate = 1'b1;
        step();
        repeat (8) step();
        gate = 1'b0;
        repeat (4) step();
        total++;
        if (env_level !== 8'd28)
            $display("FAIL retrig_pre got %0d want 28", env_level);
        else passed++;
        gate = 1'b1;
        step();
        total++;
        if (env_level !== 8'd28 || active !== 1'b1)
            $display("FAIL retrig_rise got e=%0d a=%0b want 28/1",
                     env_level, active);
        else passed++;
        repeat (3) step();
        total++;
        if (env_level !== 8'd92)
            $display("FAIL retrig_attack got %0d want 92", env_level);
        else passed++;
        gate = 1'b0;
        step();
        align();
        step();
        total++;
        if (env_level !== 8'd0 || active !== 1'b0)
            $display("FAIL retrig_release got e=%0d a=%0b want 0/0",
                     env_level, active);
        else passed++;
    endtask

    task automatic test_scaling_zero_steps();
        logic [7:0] w_in  [3] = '{8'd255, 8'd0, 8'd128};
        logic [7:0] w_exp [3] = '{8'd254, 8'd0, 8'd128};
        attack_step = 8'd0;
        decay_step = 8'd0;
        sustain_level = 8'd255;
        release_step = 8'd0;
        wave_in = 8'd128;
        align();
        gate = 1'b1;
        step();
        repeat (4) step();
        total++;
        if (env_level !== 8'd255)
            $display("FAIL zero_attack got %0d want 255", env_level);
        else passed++;
        repeat (4) step();
        total++;
        if (env_level !== 8'd255)
            $display("FAIL zero_decay got %0d want 255", env_level);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            wave_in = w_in[i];
            step();
            total++;
            if (wave_out !== w_exp[i])
                $display("FAIL scale255[%0d] got %0d want %0d",
                         i, wave_out, w_exp[i]);
            else passed++;
        end
        sustain_level = 8'd128;
        wave_in = 8'd255;
        step();
        total++;
        if (wave_out !== 8'd254 || env_level !== 8'd128)
            $display("FAIL scale_latency got w=%0d e=%0d want 254/128",
                     wave_out, env_level);
        else passed++;
        step();
        total++;
        if (wave_out !== 8'd191)
            $display("FAIL scale128 got %0d want 191", wave_out);
        else passed++;
        gate = 1'b0;
        step();
        align();
        step();
        total++;
        if (env_level !== 8'd0 || active !== 1'b0)
            $display("FAIL zero_release got e=%0d a=%0b want 0/0",
                     env_level, active);
        else passed++;
        wave_in = 8'd255;
        step();
        wave_in = 8'd0;
        total++;
        if (wave_out !== 8'd128)
            $display("FAIL scale0_hi got %0d want 128", wave_out);
        else passed++;
        step();
        total++;
        if (wave_out !== 8'd128)
            $display("FAIL scale0_lo got %0d want 128", wave_out);
        else passed++;
    endtask

    task automatic test_collision();
        attack_step = 8'd64;
        release_step = 8'd10;
        wave_in = 8'd128;
        align();
        gate = 1'b1;
        step();
        repeat (4) step();
        total++;
        if (env_level !== 8'd64)
            $display("FAIL coll_pre got %0d want 64", env_level);
        else passed++;
        align();
        gate = 1'b0;
        step();
        total++;
        if (env_level !== 8'd64 || active !== 1'b1)
            $display("FAIL coll_edge got e=%0d a=%0b want 64/1",
                     env_level, active);
        else passed++;
        repeat (4) step();
        total++;
        if (env_level !== 8'd54)
            $display("FAIL coll_release got %0d want 54", env_level);
        else passed++;
        release_step = 8'd0;
        repeat (4) step();
        total++;
        if (env_level !== 8'd0 || active !== 1'b0)
            $display("FAIL coll_done got e=%0d a=%0b want 0/0",
                     env_level, active);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_attack_decay();
        test_early_release();
        test_scaling_zero_steps();
        test_collision();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
